// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch/decode/sequence stage of the accumulator CPU.
// Owns the PC, latches the ROM word at the end of FETCH, decodes it in EXEC and
// stalls memory operations in MEM until the data memory signals ready.
// Optional feature: define CYCLE_COUNT_EN to add a saturating 32-bit cycle_count
// output that counts FETCH/EXEC/MEM cycles and clears on reset or accepted start.
module fetch_sequencer #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr,
  input  logic               acc_zero,
  input  logic [PC_W-1:0]    target,
  input  logic               mem_ready,
  output logic [PC_W-1:0]    pc,
  output logic [4:0]         alu_opcode,
  output logic [3:0]         operand,
  output logic [3:0]         lut_idx,
  output logic               acc_we,
  output logic               mem_re,
  output logic               mem_we,
  output logic               done
`ifdef CYCLE_COUNT_EN
  ,
  output logic [31:0]        cycle_count
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [4:0] OP_LOADM  = 5'd17;
  localparam logic [4:0] OP_STOREM = 5'd19;
  localparam logic [4:0] OP_STOREV = 5'd20;
  localparam logic [4:0] OP_BEQ    = 5'd22;
  localparam logic [4:0] OP_RB     = 5'd23;
  localparam logic [4:0] OP_AB     = 5'd24;
  localparam logic [4:0] OP_DONE   = 5'd31;

  // Sign-extend a 4-bit branch offset to PC width; PC arithmetic then wraps naturally.
  function automatic logic [PC_W-1:0] sext_off(input logic [3:0] off);
    return {{(PC_W-4){off[3]}}, off};
  endfunction

  // Opcodes that write the accumulator in their single EXEC cycle.
  function automatic logic is_acc_op(input logic [4:0] op);
    return (op <= 5'd16) || (op == 5'd18) || (op == 5'd21);
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic [PC_W-1:0]    pc_r;
  logic [PC_W-1:0]    pc_nxt_s;
  logic [INSTR_W-1:0] instr_r;
  logic [4:0]         op_s;
  logic [3:0]         opnd_s;
  logic               start_acc_s;

  assign op_s    = instr_r[INSTR_W-1 -: 5];
  assign opnd_s  = instr_r[3:0];
  assign pc      = pc_r;
  assign lut_idx = operand;

  // State, PC and latched instruction registers; the ROM word is captured as FETCH ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      pc_r    <= {PC_W{1'b0}};
      instr_r <= {INSTR_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      if (state_r == ST_FETCH) begin
        instr_r <= instr;
      end
    end
  end

  // Next-state, next-PC and decoded control outputs.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    start_acc_s = 1'b0;
    alu_opcode  = 5'd0;
    operand     = 4'd0;
    acc_we      = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    done        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_FETCH;
          pc_nxt_s    = {PC_W{1'b0}};
          start_acc_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_nxt_s = ST_EXEC;
      end
      ST_EXEC: begin
        alu_opcode = op_s;
        operand    = opnd_s;
        case (op_s)
          OP_LOADM: begin
            mem_re      = 1'b1;
            state_nxt_s = ST_MEM;
          end
          OP_STOREM, OP_STOREV: begin
            mem_we      = 1'b1;
            state_nxt_s = ST_MEM;
          end
          OP_BEQ: begin
            if (acc_zero) begin
              pc_nxt_s = pc_r + sext_off(opnd_s);
            end else begin
              pc_nxt_s = pc_r + PC_W'(1);
            end
            state_nxt_s = ST_FETCH;
          end
          OP_RB: begin
            pc_nxt_s    = pc_r + sext_off(opnd_s);
            state_nxt_s = ST_FETCH;
          end
          OP_AB: begin
            pc_nxt_s    = target;
            state_nxt_s = ST_FETCH;
          end
          OP_DONE: begin
            state_nxt_s = ST_HALT;
          end
          default: begin
            // ALU ops write the accumulator; 25-30 are no-ops that just advance.
            acc_we      = is_acc_op(op_s);
            pc_nxt_s    = pc_r + PC_W'(1);
            state_nxt_s = ST_FETCH;
          end
        endcase
      end
      ST_MEM: begin
        alu_opcode = op_s;
        operand    = opnd_s;
        mem_re     = (op_s == OP_LOADM);
        mem_we     = (op_s == OP_STOREM) || (op_s == OP_STOREV);
        if (mem_ready) begin
          acc_we      = (op_s == OP_LOADM);
          pc_nxt_s    = pc_r + PC_W'(1);
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_MEM;
        end
      end
      ST_HALT: begin
        done = 1'b1;
        if (start) begin
          state_nxt_s = ST_FETCH;
          pc_nxt_s    = {PC_W{1'b0}};
          start_acc_s = 1'b1;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        pc_nxt_s    = {PC_W{1'b0}};
      end
    endcase
  end

`ifdef CYCLE_COUNT_EN
  logic [31:0] cycle_count_r;

  // Saturating count of active (FETCH/EXEC/MEM) cycles, cleared by reset or accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count_r <= 32'd0;
    end else if (start_acc_s) begin
      cycle_count_r <= 32'd0;
    end else if (((state_r == ST_FETCH) || (state_r == ST_EXEC) || (state_r == ST_MEM)) &&
                 (cycle_count_r != 32'hFFFF_FFFF)) begin
      cycle_count_r <= cycle_count_r + 32'd1;
    end
  end

  assign cycle_count = cycle_count_r;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed programs plus a random program,
// checked cycle by cycle against an instruction-level reference model.
module tb_fetch_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [8:0] instr;
  logic       acc_zero;
  logic [9:0] target;
  logic       mem_ready;
  logic [9:0] pc;
  logic [4:0] alu_opcode;
  logic [3:0] operand;
  logic [3:0] lut_idx;
  logic       acc_we;
  logic       mem_re;
  logic       mem_we;
  logic       done;
`ifdef CYCLE_COUNT_EN
  logic [31:0] cycle_count;
`endif

  logic [8:0] rom [0:1023];
  logic [9:0] lut [0:15];

  int          errors;
  int          checks;
  int          m_pc;
  logic [31:0] m_cnt;
  bit          m_halted;

  fetch_sequencer #(.PC_W(10), .INSTR_W(9)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .instr      (instr),
    .acc_zero   (acc_zero),
    .target     (target),
    .mem_ready  (mem_ready),
    .pc         (pc),
    .alu_opcode (alu_opcode),
    .operand    (operand),
    .lut_idx    (lut_idx),
    .acc_we     (acc_we),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .done       (done)
`ifdef CYCLE_COUNT_EN
    ,
    .cycle_count(cycle_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM word and branch-LUT entry as seen by the stage.
  always_comb begin
    instr  = rom[pc];
    target = lut[lut_idx];
  end

  function automatic int wrap(input int v);
    return ((v % 1024) + 1024) % 1024;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
`ifdef CYCLE_COUNT_EN
    chk(tag, cycle_count, m_cnt);
`else
    m_cnt = m_cnt;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b1;
    mem_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    start = 1'b0;
    m_pc = 0;
    m_cnt = 32'd0;
    m_halted = 1'b0;
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    #1;
    step();
    start = 1'b0;
    m_pc = 0;
    m_cnt = 32'd0;
    m_halted = 1'b0;
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      mem_ready = 1'($urandom);
      acc_zero = 1'($urandom);
      #1;
      chk("halt_done", 32'(done), 32'd1);
      chk("halt_pc", 32'(pc), 32'(m_pc));
      chk("halt_strobes", 32'({acc_we, mem_re, mem_we}), 32'd0);
      chk("halt_opc", 32'(alu_opcode), 32'd0);
      chk_cnt("halt_cnt");
      step();
    end
  endtask

  // Execute one instruction from rom[m_pc]: az_mode<0 randomises acc_zero,
  // low_cycles<0 randomises the MEM stall, rst_mem aborts the MEM phase with reset.
  task automatic run_instr(input int az_mode, input int low_cycles, input bit rst_mem);
    logic [8:0] iw;
    logic [4:0] op;
    logic [3:0] opd;
    int s;
    int nxt;
    bit az;
    bit rdy;
    bit is_mem;
    iw = rom[m_pc];
    op = iw[8:4];
    opd = iw[3:0];
    s = (opd >= 4'd8) ? int'(opd) - 16 : int'(opd);
    is_mem = (op == 5'd17) || (op == 5'd19) || (op == 5'd20);
    // FETCH cycle
    start = 1'($urandom);
    acc_zero = 1'($urandom);
    mem_ready = 1'($urandom);
    #1;
    chk("fetch_pc", 32'(pc), 32'(m_pc));
    chk("fetch_opc", 32'(alu_opcode), 32'd0);
    chk("fetch_strobes", 32'({acc_we, mem_re, mem_we, done}), 32'd0);
    chk_cnt("fetch_cnt");
    step();
    m_cnt++;
    // EXEC cycle
    az = (az_mode < 0) ? 1'($urandom) : az_mode[0];
    acc_zero = az;
    mem_ready = 1'($urandom);
    start = 1'($urandom);
    #1;
    chk("exec_pc", 32'(pc), 32'(m_pc));
    chk("exec_opc", 32'(alu_opcode), 32'(op));
    chk("exec_operand", 32'(operand), 32'(opd));
    chk("exec_lut_idx", 32'(lut_idx), 32'(opd));
    chk("exec_acc_we", 32'(acc_we), 32'((op <= 5'd16) || (op == 5'd18) || (op == 5'd21)));
    chk("exec_mem_re", 32'(mem_re), 32'(op == 5'd17));
    chk("exec_mem_we", 32'(mem_we), 32'((op == 5'd19) || (op == 5'd20)));
    chk("exec_done", 32'(done), 32'd0);
    chk_cnt("exec_cnt");
    case (op)
      5'd22:   nxt = az ? wrap(m_pc + s) : wrap(m_pc + 1);
      5'd23:   nxt = wrap(m_pc + s);
      5'd24:   nxt = int'(lut[opd]);
      5'd31:   nxt = m_pc;
      default: nxt = wrap(m_pc + 1);
    endcase
    step();
    m_cnt++;
    // MEM cycles
    if (is_mem) begin
      for (int k = 0; k < 12; k++) begin
        if (rst_mem) rdy = 1'b0;
        else if (low_cycles < 0) rdy = (k == 11) || ($urandom_range(0, 2) == 0);
        else rdy = (k >= low_cycles);
        mem_ready = rdy;
        start = 1'($urandom);
        acc_zero = 1'($urandom);
        #1;
        chk("mem_pc", 32'(pc), 32'(m_pc));
        chk("mem_re", 32'(mem_re), 32'(op == 5'd17));
        chk("mem_we", 32'(mem_we), 32'((op == 5'd19) || (op == 5'd20)));
        chk("mem_acc_we", 32'(acc_we), 32'((op == 5'd17) && rdy));
        chk("mem_opc", 32'(alu_opcode), 32'(op));
        chk("mem_done", 32'(done), 32'd0);
        chk_cnt("mem_cnt");
        if (rst_mem) begin
          reset = 1'b1;
          start = 1'b1;
          step();
          reset = 1'b0;
          start = 1'b0;
          m_pc = 0;
          m_cnt = 32'd0;
          m_halted = 1'b0;
          return;
        end
        step();
        m_cnt++;
        if (rdy) break;
      end
    end
    m_pc = nxt;
    if (op == 5'd31) m_halted = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    start = 1'b0;
    acc_zero = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = {5'd25, 4'd0};
    for (int i = 0; i < 16; i++) lut[i] = 10'd0;
    @(negedge clk);

    // Reset state
    do_reset();
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_opc", 32'(alu_opcode), 32'd0);
    chk("rst_operand", 32'(operand), 32'd0);
    chk("rst_strobes", 32'({acc_we, mem_re, mem_we, done}), 32'd0);
    chk_cnt("rst_cnt");

    // Program A: add, beq both ways, then reset in the middle of a loadm
    rom[0] = {5'd0, 4'd3};
    rom[5] = {5'd22, 4'hE};
    rom[6] = {5'd17, 4'd1};
    do_start();
    run_instr(-1, -1, 1'b0);
    chk("add_next_pc", 32'(m_pc), 32'd1);
    for (int i = 0; i < 4; i++) run_instr(-1, -1, 1'b0);
    run_instr(1, -1, 1'b0);
    chk("beq_taken_pc", 32'(pc), 32'd3);
    run_instr(-1, -1, 1'b0);
    run_instr(-1, -1, 1'b0);
    run_instr(0, -1, 1'b0);
    chk("beq_fall_pc", 32'(pc), 32'd6);
    run_instr(-1, -1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("idle_pc", 32'(pc), 32'd0);
      chk("idle_strobes", 32'({acc_we, mem_re, mem_we, done}), 32'd0);
      chk_cnt("idle_cnt");
      step();
    end

    // Program B: rb wrap, ab, memory stalls, halt, restart from HALT
    do_reset();
    for (int i = 0; i < 1024; i++) rom[i] = {5'd25, 4'd0};
    rom[0]     = {5'd23, 4'hF};
    rom[1023]  = {5'd24, 4'd2};
    lut[2]     = 10'h155;
    rom[10'h155] = {5'd17, 4'd1};
    rom[10'h156] = {5'd19, 4'd5};
    rom[10'h157] = {5'd20, 4'd6};
    rom[10'h158] = {5'd24, 4'd3};
    lut[3]     = 10'd7;
    rom[7]     = {5'd31, 4'd0};
    do_start();
    run_instr(-1, -1, 1'b0);
    chk("rb_wrap_pc", 32'(pc), 32'd1023);
    run_instr(-1, -1, 1'b0);
    chk("ab_pc", 32'(pc), 32'h155);
    run_instr(-1, 3, 1'b0);
    run_instr(-1, -1, 1'b0);
    run_instr(-1, 0, 1'b0);
    run_instr(-1, -1, 1'b0);
    run_instr(-1, -1, 1'b0);
    chk("halt_flag", 32'(m_halted), 32'd1);
    halt_cycles(20);
    do_start();
    run_instr(-1, -1, 1'b0);

    // Program C: random instruction stream
    do_reset();
    for (int i = 0; i < 1024; i++) rom[i] = 9'($urandom);
    for (int i = 0; i < 16; i++) lut[i] = 10'($urandom);
    do_start();
    for (int n = 0; n < 400; n++) begin
      if (m_halted) begin
        halt_cycles(2);
        do_start();
      end
      run_instr(-1, -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
